lane_transpose_buffer: RTL and testbench

- Ping-pong transpose buffer for lane-serial state data, e.g. Keccak-style 25 lanes x 64 bits.
- Input side accepts one LANE_W-bit lane per beat, tagged with its lane index. The lane's bits scatter into column NUM_LANES-1-idx of LANE_W row registers.
- Output side streams the rows (NUM_LANES bits each, row 0 first) over a valid/ready port.
- Two banks let frame k+1 fill while frame k drains. Replaces file-dump readout with a synthesizable stream.

---
 rtl/lane_transpose_pkg.sv | 20 ++
 rtl/lane_transpose_buffer_bank.sv | 46 ++++
 rtl/lane_transpose_buffer.sv | 139 +++++++++++++
 tb/tb_lane_transpose_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_transpose_pkg.sv
// Shared constants, width helpers and FSM state types for the lane transpose buffer.
package lane_transpose_pkg;

  localparam int LANE_W_DEF    = 64;
  localparam int NUM_LANES_DEF = 25;

  // Width of a lane index for a frame of num_lanes lanes (never below 1 bit).
  function automatic int idx_width(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  // Width of a row index for lanes of lane_w bits (never below 1 bit).
  function automatic int row_width(input int lane_w);
    return (lane_w > 1) ? $clog2(lane_w) : 1;
  endfunction

  typedef enum logic {FILL = 1'b0, WAIT  = 1'b1} fill_state_t;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} drain_state_t;

endpackage

// File: rtl/lane_transpose_buffer_bank.sv
// One transpose bank: LANE_W rows of NUM_LANES bits, written one lane (column)
// at a time and read one row at a time, plus a mask of lanes written so far.
module transpose_bank
  import lane_transpose_pkg::*;
#(
  parameter  int LANE_W    = LANE_W_DEF,
  parameter  int NUM_LANES = NUM_LANES_DEF,
  localparam int IDX_W     = idx_width(NUM_LANES),
  localparam int ROW_W     = row_width(LANE_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 zero,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [LANE_W-1:0]    wr_lane,
  input  logic [ROW_W-1:0]     rd_idx,
  output logic [NUM_LANES-1:0] rd_row,
  output logic [NUM_LANES-1:0] mask
);

  logic [NUM_LANES-1:0] rows_r [LANE_W];
  logic [NUM_LANES-1:0] mask_r;
  logic [IDX_W-1:0]     col_s;

  // Lane 0 lands in the MSB column so a row reads lane 0 first.
  assign col_s = IDX_W'(NUM_LANES - 1) - wr_idx;

  // Storage: zeroing wins over a write so a flush never leaves stray bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < LANE_W; n++) rows_r[n] <= '0;
      mask_r <= '0;
    end else if (zero) begin
      for (int n = 0; n < LANE_W; n++) rows_r[n] <= '0;
      mask_r <= '0;
    end else if (wr_en) begin
      for (int n = 0; n < LANE_W; n++) rows_r[n][col_s] <= wr_lane[n];
      mask_r[wr_idx] <= 1'b1;
    end
  end

  assign rd_row = rows_r[rd_idx];
  assign mask   = mask_r;

endmodule

// File: rtl/lane_transpose_buffer.sv
// Ping-pong transpose buffer: lanes scatter into the fill bank while the other
// bank streams its rows out; banks swap roles when a frame is committed and the
// drain side is free (or finishing its last row in the same cycle).
module lane_transpose_buffer
  import lane_transpose_pkg::*;
#(
  parameter  int LANE_W    = LANE_W_DEF,
  parameter  int NUM_LANES = NUM_LANES_DEF,
  localparam int IDX_W     = idx_width(NUM_LANES),
  localparam int ROW_W     = row_width(LANE_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic [LANE_W-1:0]    in_lane,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_LANES-1:0] out_row,
  output logic [ROW_W-1:0]     out_row_idx,
  output logic                 out_last,
  output logic                 out_partial,
  output logic                 idx_err
);

  fill_state_t          fill_state_r;
  drain_state_t         drain_state_r;
  logic                 fill_sel_r;
  logic [ROW_W-1:0]     row_cnt_r;
  logic                 idx_err_r;

  logic                 accept_s;
  logic                 idx_ok_s;
  logic                 row_last_s;
  logic                 drain_last_hs_s;
  logic                 swap_s;
  logic                 drain_sel_s;
  logic                 wr_en_s   [2];
  logic                 zero_s    [2];
  logic [NUM_LANES-1:0] rd_row_s  [2];
  logic [NUM_LANES-1:0] mask_s    [2];

  assign in_ready        = (fill_state_r == FILL);
  assign accept_s        = in_valid && in_ready;
  assign idx_ok_s        = (32'(in_idx) < 32'(NUM_LANES));
  assign row_last_s      = (row_cnt_r == ROW_W'(LANE_W - 1));
  assign drain_last_hs_s = (drain_state_r == DRAIN) && out_ready && row_last_s;
  assign swap_s          = (fill_state_r == WAIT) &&
                           ((drain_state_r == IDLE) || drain_last_hs_s);
  assign drain_sel_s     = ~fill_sel_r;
  assign idx_err         = idx_err_r;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    // Only the fill bank takes writes; the outgoing drain bank is wiped on swap.
    assign wr_en_s[b] = accept_s && idx_ok_s && (fill_sel_r == 1'(b));
    assign zero_s[b]  = clear || (swap_s && (fill_sel_r != 1'(b)));

    transpose_bank #(
      .LANE_W    (LANE_W),
      .NUM_LANES (NUM_LANES)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .zero    (zero_s[b]),
      .wr_en   (wr_en_s[b]),
      .wr_idx  (in_idx),
      .wr_lane (in_lane),
      .rd_idx  (row_cnt_r),
      .rd_row  (rd_row_s[b]),
      .mask    (mask_s[b])
    );
  end

  // Output decode: everything is driven from state flops and bank flops only.
  always_comb begin
    out_valid   = 1'b0;
    out_row     = '0;
    out_row_idx = '0;
    out_last    = 1'b0;
    out_partial = 1'b0;
    if (drain_state_r == DRAIN) begin
      out_valid   = 1'b1;
      out_row     = rd_row_s[drain_sel_s];
      out_row_idx = row_cnt_r;
      out_last    = row_last_s;
      out_partial = ~&mask_s[drain_sel_s];
    end else begin
      out_valid   = 1'b0;
    end
  end

  // Fill/drain FSMs, bank select, row counter and bad-index pulse; clear beats every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_state_r  <= FILL;
      drain_state_r <= IDLE;
      fill_sel_r    <= 1'b0;
      row_cnt_r     <= '0;
      idx_err_r     <= 1'b0;
    end else if (clear) begin
      fill_state_r  <= FILL;
      drain_state_r <= IDLE;
      fill_sel_r    <= 1'b0;
      row_cnt_r     <= '0;
      idx_err_r     <= 1'b0;
    end else begin
      idx_err_r <= accept_s && !idx_ok_s;

      case (fill_state_r)
        FILL: if (accept_s && in_last) fill_state_r <= WAIT;
        WAIT: if (swap_s) begin
          fill_state_r <= FILL;
          fill_sel_r   <= ~fill_sel_r;
        end
        default: fill_state_r <= FILL;
      endcase

      case (drain_state_r)
        IDLE: if (swap_s) begin
          drain_state_r <= DRAIN;
          row_cnt_r     <= '0;
        end
        DRAIN: if (out_ready) begin
          if (row_last_s) begin
            row_cnt_r     <= '0;
            drain_state_r <= swap_s ? DRAIN : IDLE;
          end else begin
            row_cnt_r     <= row_cnt_r + ROW_W'(1);
          end
        end
        default: drain_state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_transpose_buffer.sv
// Randomized scoreboard bench for lane_transpose_buffer: a frame-level model
// turns committed lanes into the expected row stream, checked on every cycle.
module tb_lane_transpose_buffer;
  import lane_transpose_pkg::*;

  localparam int LW = 64;
  localparam int NL = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_idx;
  logic [LW-1:0] in_lane;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [NL-1:0] out_row;
  logic [5:0]    out_row_idx;
  logic          out_last;
  logic          out_partial;
  logic          idx_err;

  lane_transpose_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
    .in_lane     (in_lane),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .out_partial (out_partial),
    .idx_err     (idx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] row;
    int            idx;
    bit            last;
    bit            partial;
  } beat_t;

  beat_t         exp_q[$];
  logic [LW-1:0] m_lane    [NL];
  bit            m_written [NL];
  int            checks = 0;
  int            errors = 0;
  bit            exp_idx_err;
  bit            rdy_rand;
  bit            rdy_val;
  bit            s_out_valid;
  bit            s_in_ready;
  logic [5:0]    s_row_idx;
  int            run_len;
  int            max_run;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void frame_reset();
    for (int i = 0; i < NL; i++) begin
      m_lane[i]    = '0;
      m_written[i] = 1'b0;
    end
  endfunction

  function automatic void model_flush();
    frame_reset();
    exp_q.delete();
    exp_idx_err = 1'b0;
    run_len     = 0;
  endfunction

  // Row r of a frame holds bit r of every lane, lane 0 in the MSB.
  function automatic void model_commit();
    bit partial = 1'b0;
    for (int i = 0; i < NL; i++) if (!m_written[i]) partial = 1'b1;
    for (int r = 0; r < LW; r++) begin
      beat_t b;
      b.row = '0;
      for (int i = 0; i < NL; i++) b.row[NL-1-i] = m_lane[i][r];
      b.idx     = r;
      b.last    = (r == LW - 1);
      b.partial = partial;
      exp_q.push_back(b);
    end
    frame_reset();
  endfunction

  function automatic void model_accept(input logic [4:0] idx, input logic [LW-1:0] lane, input bit last);
    if (int'(idx) < NL) begin
      m_lane[idx]    = lane;
      m_written[idx] = 1'b1;
    end
    if (last) model_commit();
  endfunction

  // One clock: sample and check at the falling edge, then present new inputs.
  task automatic drive_cycle(input bit v, input logic [4:0] idx, input logic [LW-1:0] lane,
                             input bit last, output bit acc);
    bit ordy;
    @(negedge clk);
    s_out_valid = out_valid;
    s_in_ready  = in_ready;
    s_row_idx   = out_row_idx;
    check_val("idx_err", 64'(idx_err), 64'(exp_idx_err));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 64'(out_valid), 64'(0));
      end else begin
        check_val("out_row",     64'(out_row),     64'(exp_q[0].row));
        check_val("out_row_idx", 64'(out_row_idx), 64'(exp_q[0].idx));
        check_val("out_last",    64'(out_last),    64'(exp_q[0].last));
        check_val("out_partial", 64'(out_partial), 64'(exp_q[0].partial));
      end
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    ordy      = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    in_valid  = v;
    in_idx    = idx;
    in_lane   = lane;
    in_last   = last;
    out_ready = ordy;
    acc       = v && s_in_ready;
    if (out_valid && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    exp_idx_err = acc && (int'(idx) >= NL);
    if (acc) model_accept(idx, lane, last);
  endtask

  task automatic send_beat(input logic [4:0] idx, input logic [LW-1:0] lane, input bit last);
    bit acc = 1'b0;
    for (int k = 0; k < 5000 && !acc; k++) drive_cycle(1'b1, idx, lane, last, acc);
    if (!acc) check_val("in_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 5'd0, '0, 1'b0, acc);
  endtask

  task automatic wait_drain();
    bit acc;
    for (int k = 0; k < 3000; k++) begin
      drive_cycle(1'b0, 5'd0, '0, 1'b0, acc);
      if (exp_q.size() == 0 && !s_out_valid) break;
    end
    check_val("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"},    64'(in_ready),    64'(1));
    check_val({tag, "_out_valid"},   64'(out_valid),   64'(0));
    check_val({tag, "_out_row"},     64'(out_row),     64'(0));
    check_val({tag, "_out_row_idx"}, 64'(out_row_idx), 64'(0));
    check_val({tag, "_out_last"},    64'(out_last),    64'(0));
    check_val({tag, "_out_partial"}, 64'(out_partial), 64'(0));
    check_val({tag, "_idx_err"},     64'(idx_err),     64'(0));
  endtask

  // Reset (rst) or flush (clear) with a live beat presented to show it is discarded.
  task automatic do_reset(input bit use_clear);
    @(negedge clk);
    in_valid  = 1'b1;
    in_idx    = 5'd20;
    in_lane   = '1;
    in_last   = 1'b1;
    out_ready = 1'b1;
    if (use_clear) clear = 1'b1;
    else           rst   = 1'b1;
    model_flush();
    @(negedge clk);
    check_reset_outputs(use_clear ? "clear" : "rst");
    rst      = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic mid_drain_reset(input bit use_clear);
    bit acc;
    bit hit = 1'b0;
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    for (int i = 0; i < NL; i++) send_beat(5'(i), {$urandom, $urandom}, i == NL - 1);
    for (int k = 0; k < 200 && !hit; k++) begin
      drive_cycle(1'b0, 5'd0, '0, 1'b0, acc);
      hit = s_out_valid && (s_row_idx == 6'd10);
    end
    check_val("reach_row10", 64'(hit), 64'(1));
    do_reset(use_clear);
    for (int i = 0; i < 10; i++) send_beat(5'(i), {$urandom, $urandom}, i == 9);
    wait_drain();
  endtask

  initial begin
    bit acc;
    int cnt;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_idx = '0; in_lane = '0;
    in_last = 1'b0; out_ready = 1'b0; rdy_rand = 1'b0; rdy_val = 1'b1;
    max_run = 0;
    model_flush();
    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    rst = 1'b0;

    // Single frame of alternating lanes: odd lanes set -> 25'h0AAAAAA each row.
    for (int i = 0; i < NL; i++) send_beat(5'(i), {LW{i[0]}}, i == NL - 1);
    idle(1);
    check_val("latency_gap", 64'(s_out_valid), 64'(0));
    idle(1);
    check_val("latency_first", 64'(s_out_valid), 64'(1));
    check_val("single_row0", 64'(out_row), 64'(25'h0AAAAAA));
    wait_drain();

    // Partial frame with only lane 3 written.
    send_beat(5'd3, '1, 1'b1);
    idle(2);
    check_val("partial_row", 64'(out_row), 64'(25'h0200000));
    check_val("partial_flag", 64'(out_partial), 64'(1));
    wait_drain();

    // Back-to-back frames stream without a bubble.
    max_run = 0;
    for (int i = 0; i < NL; i++) send_beat(5'(i), '1, i == NL - 1);
    for (int i = 0; i < NL; i++) send_beat(5'(i), '0, i == NL - 1);
    wait_drain();
    check_val("b2b_run", 64'(max_run), 64'(128));

    // Backpressure: drain stalled, second frame committed, third frame blocked.
    rdy_val = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NL; i++) send_beat(5'(i), {$urandom, $urandom}, i == NL - 1);
    idle(3);
    check_val("bp_in_ready", 64'(s_in_ready), 64'(0));
    check_val("bp_hold_idx", 64'(s_row_idx), 64'(0));
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b1, 5'd0, {$urandom, $urandom}, 1'b0, acc);
      cnt += int'(acc);
    end
    check_val("bp_no_accept", 64'(cnt), 64'(0));
    rdy_rand = 1'b1;
    for (int i = 0; i < NL; i++) send_beat(5'(i), {$urandom, $urandom}, i == NL - 1);
    wait_drain();

    // Bad index: dropped with a one-cycle pulse; a bad last still commits.
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(5'(i), {$urandom, $urandom}, 1'b0);
    send_beat(5'd27, '1, 1'b0);
    idle(1);
    check_val("bad_idx_pulse", 64'(idx_err), 64'(1));
    send_beat(5'd27, '1, 1'b1);
    wait_drain();

    mid_drain_reset(1'b0);
    mid_drain_reset(1'b1);

    // Randomized frames: repeated and out-of-range indices, random stalls.
    rdy_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int nb = $urandom_range(1, 30);
      for (int b = 0; b < nb; b++) begin
        logic [4:0] idx;
        idx = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
        send_beat(idx, {$urandom, $urandom}, b == nb - 1);
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
